// File: rtl/bus_master_arb_pkg.sv
// Shared bus definitions for the four-master bus arbiter: widths, owner
// encodings and the round-robin successor function.
package bus_master_arb_pkg;

   localparam int BUS_MASTER_CH_DEF = 4;
   localparam int WORD_ADDR_W       = 30;
   localparam int WORD_DATA_W       = 32;

   localparam logic BUS_READ  = 1'b1;
   localparam logic BUS_WRITE = 1'b0;

   typedef enum logic [1:0] {
      BUS_OWNER_MASTER_0 = 2'd0,
      BUS_OWNER_MASTER_1 = 2'd1,
      BUS_OWNER_MASTER_2 = 2'd2,
      BUS_OWNER_MASTER_3 = 2'd3
   } owner_e;

   // Next owner: hold while the owner requests (or nobody else does), else
   // the first requester after the owner in index order, wrapping at 4.
   function automatic owner_e rr_next(owner_e cur, logic [3:0] req_n);
      owner_e     nxt;
      logic [1:0] idx;
      nxt = cur;
      if (req_n[cur]) begin
         for (int k = 3; k >= 1; k--) begin
            idx = cur + 2'(k);
            if (!req_n[idx]) begin
               nxt = owner_e'(idx);
            end
         end
      end
      return nxt;
   endfunction

endpackage

// File: rtl/bus_master_arb_mux.sv
// Slave-side bus selection: purely combinational copy of the owning master's
// address, strobe, access type and write data.
module bus_master_arb_mux
   import bus_master_arb_pkg::*;
(
   input  owner_e                           owner,
   input  logic [4*WORD_ADDR_W-1:0]         m_addr,
   input  logic [3:0]                       m_as_,
   input  logic [3:0]                       m_rw,
   input  logic [4*WORD_DATA_W-1:0]         m_wr_data,
   output logic [WORD_ADDR_W-1:0]           s_addr,
   output logic                             s_as_,
   output logic                             s_rw,
   output logic [WORD_DATA_W-1:0]           s_wr_data
);

   // Non-owners never reach the slave side; an idle strobe is the default.
   always_comb begin
      s_addr    = m_addr[0 +: WORD_ADDR_W];
      s_as_     = m_as_[0];
      s_rw      = m_rw[0];
      s_wr_data = m_wr_data[0 +: WORD_DATA_W];
      case (owner)
         BUS_OWNER_MASTER_0: begin
            s_addr    = m_addr[0*WORD_ADDR_W +: WORD_ADDR_W];
            s_as_     = m_as_[0];
            s_rw      = m_rw[0];
            s_wr_data = m_wr_data[0*WORD_DATA_W +: WORD_DATA_W];
         end
         BUS_OWNER_MASTER_1: begin
            s_addr    = m_addr[1*WORD_ADDR_W +: WORD_ADDR_W];
            s_as_     = m_as_[1];
            s_rw      = m_rw[1];
            s_wr_data = m_wr_data[1*WORD_DATA_W +: WORD_DATA_W];
         end
         BUS_OWNER_MASTER_2: begin
            s_addr    = m_addr[2*WORD_ADDR_W +: WORD_ADDR_W];
            s_as_     = m_as_[2];
            s_rw      = m_rw[2];
            s_wr_data = m_wr_data[2*WORD_DATA_W +: WORD_DATA_W];
         end
         BUS_OWNER_MASTER_3: begin
            s_addr    = m_addr[3*WORD_ADDR_W +: WORD_ADDR_W];
            s_as_     = m_as_[3];
            s_rw      = m_rw[3];
            s_wr_data = m_wr_data[3*WORD_DATA_W +: WORD_DATA_W];
         end
         default: begin
            s_as_ = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/bus_master_arb.sv
// Four-master round-robin bus arbiter with parked, non-preemptive grants.
// owner is the only state; grants are decoded from it.
//
//   state               | meaning
//   BUS_OWNER_MASTER_0  | CPU IF port owns the bus (reset / parked default)
//   BUS_OWNER_MASTER_1  | CPU MEM port owns the bus
//   BUS_OWNER_MASTER_2  | spare / DMA master 2 owns the bus
//   BUS_OWNER_MASTER_3  | spare / DMA master 3 owns the bus
module bus_master_arb
   import bus_master_arb_pkg::*;
#(
   parameter int BUS_MASTER_CH = BUS_MASTER_CH_DEF
)(
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [BUS_MASTER_CH-1:0]             m_req_,
   input  logic [BUS_MASTER_CH*WORD_ADDR_W-1:0] m_addr,
   input  logic [BUS_MASTER_CH-1:0]             m_as_,
   input  logic [BUS_MASTER_CH-1:0]             m_rw,
   input  logic [BUS_MASTER_CH*WORD_DATA_W-1:0] m_wr_data,
   output logic [BUS_MASTER_CH-1:0]             m_grnt_,
   output logic [WORD_ADDR_W-1:0]               s_addr,
   output logic                                 s_as_,
   output logic                                 s_rw,
   output logic [WORD_DATA_W-1:0]               s_wr_data
);

   owner_e owner_q;
   owner_e owner_d;

   // Reset forces master 0 immediately, aborting any transfer in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner_q <= BUS_OWNER_MASTER_0;
      end else begin
         owner_q <= owner_d;
      end
   end

   always_comb begin
      owner_d          = owner_q;
      m_grnt_          = '1;
      owner_d          = rr_next(owner_q, m_req_);
      m_grnt_[owner_q] = 1'b0;
   end

   bus_master_arb_mux u_mux (
      .owner     (owner_q),
      .m_addr    (m_addr),
      .m_as_     (m_as_),
      .m_rw      (m_rw),
      .m_wr_data (m_wr_data),
      .s_addr    (s_addr),
      .s_as_     (s_as_),
      .s_rw      (s_rw),
      .s_wr_data (s_wr_data)
   );

endmodule

// File: tb/tb_bus_master_arb.sv
// Directed bench for bus_master_arb with a short randomized tail checked
// against a reference round-robin model.
module tb_bus_master_arb;
   import bus_master_arb_pkg::*;

   logic          clk;
   logic          reset;
   logic [3:0]    m_req_;
   logic [119:0]  m_addr;
   logic [3:0]    m_as_;
   logic [3:0]    m_rw;
   logic [127:0]  m_wr_data;
   logic [3:0]    m_grnt_;
   logic [29:0]   s_addr;
   logic          s_as_;
   logic          s_rw;
   logic [31:0]   s_wr_data;

   int checks;
   int errors;

   bus_master_arb dut (
      .clk       (clk),
      .reset     (reset),
      .m_req_    (m_req_),
      .m_addr    (m_addr),
      .m_as_     (m_as_),
      .m_rw      (m_rw),
      .m_wr_data (m_wr_data),
      .m_grnt_   (m_grnt_),
      .s_addr    (s_addr),
      .s_as_     (s_as_),
      .s_rw      (s_rw),
      .s_wr_data (s_wr_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_addr(input int i, input logic [29:0] a);
      m_addr[i*30 +: 30] = a;
   endtask

   function automatic logic [1:0] model_next(input logic [1:0] own, input logic [3:0] req_n);
      logic [1:0] cand;
      if (req_n[own] == 1'b0) return own;
      for (int k = 1; k <= 3; k++) begin
         cand = own + 2'(k);
         if (req_n[cand] == 1'b0) return cand;
      end
      return own;
   endfunction

   initial begin
      logic [1:0] mown;
      logic [1:0] mnext;
      logic [3:0] exp_g;
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      m_req_ = 4'b1111;
      m_as_  = 4'b1111;
      m_rw   = 4'b0101;
      m_addr = '0;
      for (int i = 0; i < 4; i++) begin
         set_addr(i, 30'(32'h10 * (i + 1)));
         m_wr_data[i*32 +: 32] = 32'hD000_0000 + 32'(i);
      end
      #12;
      chk("rst_grnt", 32'(m_grnt_), 32'h0000_000E);
      chk("rst_s_addr", 32'(s_addr), 32'h10);
      chk("rst_s_rw", 32'(s_rw), 32'h1);
      chk("rst_s_wdata", s_wr_data, 32'hD000_0000);

      // parked on master 0 with no requests
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("park0", 32'(m_grnt_), 32'h0000_000E);
      end

      // owner 0 holds against master 1, then hands over on release
      m_req_ = 4'b1100;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("hold0", 32'(m_grnt_), 32'h0000_000E);
      end
      m_req_ = 4'b1101;
      #2;
      chk("no_comb_grant", 32'(m_grnt_), 32'h0000_000E);
      tick();
      chk("grant1", 32'(m_grnt_), 32'h0000_000D);
      chk("s_addr_m1", 32'(s_addr), 32'h20);

      // everyone requests: owner 1 holds, then round-robin 2, 3, 0
      m_req_ = 4'b0000;
      tick();
      chk("hold1_all", 32'(m_grnt_), 32'h0000_000D);
      m_req_ = 4'b0010;
      tick();
      chk("grant2", 32'(m_grnt_), 32'h0000_000B);

      // owner 2: only master 2's strobe/address/data reach the slave side
      m_as_ = 4'b0000;
      #1;
      chk("s_addr_m2", 32'(s_addr), 32'h30);
      chk("s_as_m2_low", 32'(s_as_), 32'h0);
      chk("s_wdata_m2", s_wr_data, 32'hD000_0002);
      m_as_ = 4'b0100;
      #1;
      chk("s_as_m2_high", 32'(s_as_), 32'h1);
      m_as_ = 4'b1011;
      #1;
      chk("s_as_m2_only", 32'(s_as_), 32'h0);
      m_as_ = 4'b1111;

      m_req_ = 4'b0110;
      tick();
      chk("grant3", 32'(m_grnt_), 32'h0000_0007);
      m_req_ = 4'b1110;
      tick();
      chk("grant0_wrap", 32'(m_grnt_), 32'h0000_000E);

      // owner 0 releases to master 3 only
      m_req_ = 4'b0111;
      tick();
      chk("grant3_skip", 32'(m_grnt_), 32'h0000_0007);
      m_req_ = 4'b1111;
      tick();
      chk("park3", 32'(m_grnt_), 32'h0000_0007);
      m_req_ = 4'b0111;
      m_as_  = 4'b0111;
      #1;
      chk("s_rw_m3", 32'(s_rw), 32'h0);

      // reset mid-write while owner is 3: grant returns before any edge
      @(negedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("rst_async_grnt", 32'(m_grnt_), 32'h0000_000E);
      chk("rst_async_rw", 32'(s_rw), 32'h1);
      chk("rst_async_addr", 32'(s_addr), 32'h10);
      @(negedge clk);
      reset = 1'b0;
      m_as_ = 4'b1111;
      tick();
      chk("first_arb", 32'(m_grnt_), 32'h0000_0007);

      // owner 3 released with masters 0 and 1 requesting: 0 is next
      m_req_ = 4'b1100;
      tick();
      chk("wrap_to0", 32'(m_grnt_), 32'h0000_000E);

      // randomized tail against the reference model
      mown = 2'd0;
      for (int c = 0; c < 400; c++) begin
         m_req_ = 4'($urandom_range(0, 15));
         m_as_  = 4'($urandom_range(0, 15));
         m_rw   = 4'($urandom_range(0, 15));
         for (int i = 0; i < 4; i++) begin
            set_addr(i, 30'($urandom));
            m_wr_data[i*32 +: 32] = $urandom;
         end
         #1;
         exp_g = 4'b1111;
         exp_g[mown] = 1'b0;
         chk("rnd_grnt", 32'(m_grnt_), 32'(exp_g));
         chk("rnd_s_addr", 32'(s_addr), 32'(m_addr[mown*30 +: 30]));
         chk("rnd_s_wdata", s_wr_data, m_wr_data[mown*32 +: 32]);
         chk("rnd_s_ctl", {30'd0, s_as_, s_rw}, {30'd0, m_as_[mown], m_rw[mown]});
         mnext = model_next(mown, m_req_);
         tick();
         mown = mnext;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running exp finished");
      $fatal(1);
   end

endmodule

// File: doc/bus_master_arb.md
BUS_MASTER_ARB -- requirements
Module: bus_master_arb

Interface
REQ-001 Parameter BUS_MASTER_CH, default 4, number of bus masters arbitrated; fixed at 4 in this SoC.
REQ-002 Master 0 = CPU IF port, master 1 = CPU MEM port, masters 2-3 = spare or DMA; index order is the round-robin order.
REQ-003 clk  in  1  system clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 m_req_  in  4  per-master bus request, active low; bit i = master i.
REQ-006 m_addr  in  4x`WordAddrBus (4x30)  per-master word address, master i in slice i.
REQ-007 m_as_  in  4  per-master address strobe, active low.
REQ-008 m_rw  in  4  per-master access type, `READ/`WRITE.
REQ-009 m_wr_data  in  4x`WordDataBus (4x32)  per-master write data.
REQ-010 m_grnt_  out  4  per-master grant, active low, one-hot-low, registered.
REQ-011 s_addr  out  `WordAddrBus  address to the slave-side bus.
REQ-012 s_as_  out  1  strobe to the slave-side bus.
REQ-013 s_rw  out  1  access type to the slave-side bus.
REQ-014 s_wr_data  out  `WordDataBus  write data to the slave-side bus.

Function
REQ-015 Internal state: 2-bit register owner; exactly one m_grnt_ bit is low at all times, bit [owner].
REQ-016 While m_req_[owner] is low, owner SHALL hold; no preemption, no tenure limit.
REQ-017 When m_req_[owner] is high at a rising edge, owner SHALL become the first i in order owner+1, owner+2, owner+3 (mod 4) with m_req_[i] low.
REQ-018 If m_req_[owner] is high and no other master requests, owner SHALL hold (parked grant).
REQ-019 Grant latency: master requesting into an idle, parked bus receives m_grnt_ low one clk after the edge that samples its request, provided the owner's request is high.
REQ-020 Handover: owner release and new grant occur on the same edge; no idle cycle is inserted between owners.
REQ-021 Simultaneous requests on a release: the requester nearest after owner in round-robin order wins; others wait, with no starvation beyond 3 tenures.
REQ-022 s_addr, s_as_, s_rw, s_wr_data SHALL be combinational copies of master [owner] signals, with no added latency.
REQ-023 Strobes, addresses and data from non-owners SHALL never reach the slave side.
REQ-024 A master whose m_grnt_ is high SHALL NOT have its m_as_ observed; an early m_as_ is harmless.
REQ-025 m_req_ values other than 0/1 (X) are not supported; behaviour is undefined.

Reset
REQ-026 On reset assertion, owner SHALL be 0 and m_grnt_ SHALL be 4'b1110 asynchronously.
REQ-027 During reset, s_* SHALL mirror master 0's inputs.
REQ-028 Reset during a transaction SHALL abort it immediately; the grant returns to master 0 with no completion handshake.
REQ-029 First arbitration occurs at the first rising edge after reset deasserts.

Structure
REQ-030 BUS_MASTER_CH, owner encodings (BUS_OWNER_MASTER_0..3) and the `WordAddrBus/`WordDataBus widths belong in the shared bus.h header.
REQ-031 The block has one sub-module, bus_master_mux, which is the pure combinational selection of s_* from owner; the arbiter FSM is kept in bus_master_arb.
REQ-032 Only owner is state; m_grnt_ is decoded from a registered owner, so no glitches.

Verification
REQ-033 Reset with all m_req_=4'b1111 -> m_grnt_=4'b1110, s_addr=m_addr[0], remains parked for 10 cycles.
REQ-034 Owner 0 holds; m_req_=4'b1100 for 5 cycles, then 4'b1101 -> m_grnt_ stays 1110 for 5 cycles, then 4'b1101 one edge after release.
REQ-035 Owner 1 releases while m_req_[0],[2],[3] are all low -> m_grnt_=4'b1011 (master 2), then on its release 4'b0111, then 4'b1110.
REQ-036 Owner 2 with m_as_=4'b0000 and distinct addresses 0x10,0x20,0x30,0x40 -> s_addr=0x30 and s_as_ follows m_as_[2] only.
REQ-037 Reset pulse mid-write while owner=3 -> m_grnt_=4'b1110 before the next clk edge and s_rw follows m_rw[0].
REQ-038 Random 10k-cycle requests with a scoreboard -> always exactly one grant; every requester granted within 3 owner tenures; s_* always equals the owner's inputs.
